// File: rtl/tp_pkg.sv
// Shared types for the crossing dispatcher: default widths, FSM states and
// the buffered crossing entry layout.
package tp_pkg;

  localparam int CNT_W_DEFAULT      = 6;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    ACK   = 2'd2,
    BUSY  = 2'd3
  } tp_state_e;

  typedef struct packed {
    logic [CNT_W_DEFAULT-1:0] a;
    logic [CNT_W_DEFAULT-1:0] b;
    logic [CNT_W_DEFAULT-1:0] c;
  } xing_entry_t;

endpackage

// File: rtl/tp_crossing_dispatch_if.sv
// Bundle of the writer-side push port and the processor-side handshake.
// master drives crossings and processor status; slave is the dispatcher.
interface tp_crossing_dispatch_if import tp_pkg::*; #(
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             xing_valid;
  logic             xing_ready;
  logic [CNT_W-1:0] cnt_a_in;
  logic [CNT_W-1:0] cnt_b_in;
  logic [CNT_W-1:0] cnt_c_in;
  logic             proc_bsy;
  logic             cnt_en_a;
  logic             cnt_en_b;
  logic             cnt_en_c;
  logic             start_proc;
  logic             zero_a;
  logic             zero_b;
  logic             zero_c;
  logic [CNT_W-1:0] trk_idx_a;
  logic [CNT_W-1:0] trk_idx_b;
  logic [CNT_W-1:0] trk_idx_c;
  logic             xing_done;
  logic [LVL_W-1:0] fifo_level;

  modport master (
    output xing_valid, cnt_a_in, cnt_b_in, cnt_c_in,
    output proc_bsy, cnt_en_a, cnt_en_b, cnt_en_c,
    input  xing_ready, start_proc, zero_a, zero_b, zero_c,
    input  trk_idx_a, trk_idx_b, trk_idx_c, xing_done, fifo_level
  );

  modport slave (
    input  xing_valid, cnt_a_in, cnt_b_in, cnt_c_in,
    input  proc_bsy, cnt_en_a, cnt_en_b, cnt_en_c,
    output xing_ready, start_proc, zero_a, zero_b, zero_c,
    output trk_idx_a, trk_idx_b, trk_idx_c, xing_done, fifo_level
  );

endinterface

// File: rtl/tp_xing_fifo.sv
// Small synchronous FIFO of crossing entries; the head entry is readable
// combinationally so a pop can load the counters on the same edge.
module tp_xing_fifo #(
  parameter  int WIDTH = 18,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign rdata = mem[rd_ptr_reg];
  assign full  = (level_reg == LVL_W'(DEPTH));
  assign empty = (level_reg == '0);
  assign level = level_reg;

endmodule

// File: rtl/tp_crossing_dispatch.sv
// Crossing dispatcher: queues per-crossing tracklet counts, hands one
// crossing at a time to the processor and serves its drain counters.
module tp_crossing_dispatch import tp_pkg::*; #(
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input logic                   clk,
  input logic                   res_n,
  tp_crossing_dispatch_if.slave bus
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = 3 * CNT_W;

  tp_state_e        state_reg;
  tp_state_e        state_next;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [ENT_W-1:0] wdata;
  logic [ENT_W-1:0] rdata;
  logic [LVL_W-1:0] level;
  logic [2:0]       cnt_en;
  logic [CNT_W-1:0] cnt_val [3];
  logic             start_proc;
  logic             xing_done;

  assign push  = bus.xing_valid && !full;
  assign pop   = (state_reg == IDLE) && !empty && !bus.proc_bsy;
  assign wdata = {bus.cnt_a_in, bus.cnt_b_in, bus.cnt_c_in};

  tp_xing_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .res_n (res_n),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    start_proc = 1'b0;
    xing_done  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pop) begin
          state_next = START;
        end
      end
      START: begin
        start_proc = 1'b1;
        state_next = ACK;
      end
      ACK: begin
        if (bus.proc_bsy) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (!bus.proc_bsy) begin
          xing_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Index 0/1/2 = block A/B/C; entry packs A in the most significant field.
  assign cnt_en = {bus.cnt_en_c, bus.cnt_en_b, bus.cnt_en_a};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] load_val;

    assign load_val = rdata[(3-gi)*CNT_W-1 -: CNT_W];

    // A pop load wins over a same-cycle decrement; zero saturates.
    always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
        cnt_reg <= '0;
      end else if (pop) begin
        cnt_reg <= load_val;
      end else if (cnt_en[gi] && (cnt_reg != '0)) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end

    assign cnt_val[gi] = cnt_reg;
  end

  assign bus.xing_ready = !full;
  assign bus.fifo_level = level;
  assign bus.start_proc = start_proc;
  assign bus.xing_done  = xing_done;
  assign bus.trk_idx_a  = cnt_val[0];
  assign bus.trk_idx_b  = cnt_val[1];
  assign bus.trk_idx_c  = cnt_val[2];
  assign bus.zero_a     = (cnt_val[0] == '0);
  assign bus.zero_b     = (cnt_val[1] == '0);
  assign bus.zero_c     = (cnt_val[2] == '0);

endmodule

// File: tb/tb_tp_crossing_dispatch.sv
// Directed bench for tp_crossing_dispatch: a scoreboard queue holds pushed
// crossings and is compared against the counters at each start_proc.
module tb_tp_crossing_dispatch;
  import tp_pkg::*;

  localparam int CNT_W      = 6;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic res_n;

  always #5 clk = ~clk;

  tp_crossing_dispatch_if #(.CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  tp_crossing_dispatch #(.CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  xing_entry_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input tp_state_e exp);
    chk(tag, 32'(dut.state_reg), 32'(exp));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input int b, input int c);
    xing_entry_t e;
    e.a = CNT_W'(a);
    e.b = CNT_W'(b);
    e.c = CNT_W'(c);
    bus.xing_valid = 1'b1;
    bus.cnt_a_in   = e.a;
    bus.cnt_b_in   = e.b;
    bus.cnt_c_in   = e.c;
    chk("push_ready", bus.xing_ready, 1);
    sb.push_back(e);
    cyc();
    bus.xing_valid = 1'b0;
    $display("push  a=%0d b=%0d c=%0d level=%0d", a, b, c, bus.fifo_level);
  endtask

  // Wait (bounded) for start_proc, then compare counters to the scoreboard head.
  task automatic wait_start(input string tag, input int budget);
    xing_entry_t exp;
    int          left;
    left = budget;
    while (bus.start_proc !== 1'b1 && left > 0) begin
      cyc();
      left--;
    end
    chk({tag, "_start"}, bus.start_proc, 1);
    exp = '1;
    if (sb.size() != 0) exp = sb.pop_front();
    chk({tag, "_idx_a"}, bus.trk_idx_a, exp.a);
    chk({tag, "_idx_b"}, bus.trk_idx_b, exp.b);
    chk({tag, "_idx_c"}, bus.trk_idx_c, exp.c);
    chk({tag, "_zero_a"}, bus.zero_a, exp.a == '0);
    $display("start a=%0d b=%0d c=%0d", bus.trk_idx_a, bus.trk_idx_b, bus.trk_idx_c);
  endtask

  // Processor model from the START cycle: ack, stay busy, then release.
  task automatic finish_xing(input string tag, input int busy);
    bus.proc_bsy = 1'b1;
    cyc();
    chk_state({tag, "_ack"}, ACK);
    chk({tag, "_start_once"}, bus.start_proc, 0);
    cyc();
    for (int i = 0; i < busy; i++) begin
      chk_state({tag, "_busy_hold"}, BUSY);
      chk({tag, "_done_early"}, bus.xing_done, 0);
      cyc();
    end
    chk_state({tag, "_busy"}, BUSY);
    bus.proc_bsy = 1'b0;
    #1;
    chk({tag, "_done"}, bus.xing_done, 1);
    cyc();
    chk({tag, "_done_pulse"}, bus.xing_done, 0);
    $display("done  %s", tag);
  endtask

  initial begin
    res_n          = 1'b0;
    bus.xing_valid = 1'b0;
    bus.cnt_a_in   = '0;
    bus.cnt_b_in   = '0;
    bus.cnt_c_in   = '0;
    bus.proc_bsy   = 1'b0;
    bus.cnt_en_a   = 1'b0;
    bus.cnt_en_b   = 1'b0;
    bus.cnt_en_c   = 1'b0;
    repeat (2) cyc();
    res_n = 1'b1;
    cyc();

    chk_state("rst_state", IDLE);
    chk("rst_level", bus.fifo_level, 0);
    chk("rst_ready", bus.xing_ready, 1);
    chk("rst_zero_a", bus.zero_a, 1);
    chk("rst_zero_b", bus.zero_b, 1);
    chk("rst_zero_c", bus.zero_c, 1);
    chk("rst_idx_a", bus.trk_idx_a, 0);
    chk("rst_start", bus.start_proc, 0);
    chk("rst_done", bus.xing_done, 0);

    // Crossing {3,0,2}: exact latency and per-block drain.
    push(3, 0, 2);
    chk("a_level1", bus.fifo_level, 1);
    chk_state("a_idle", IDLE);
    cyc();
    wait_start("a", 0);
    chk("a_level0", bus.fifo_level, 0);
    bus.proc_bsy = 1'b1;
    cyc();
    chk("a_start_once", bus.start_proc, 0);
    chk_state("a_ack", ACK);
    cyc();
    chk_state("a_busy", BUSY);
    for (int i = 0; i < 5; i++) begin
      chk("a_drain_a", bus.trk_idx_a, (i <= 3) ? 3 - i : 0);
      chk("a_drain_zero_a", bus.zero_a, (i >= 3) ? 1 : 0);
      bus.cnt_en_a = 1'b1;
      cyc();
    end
    bus.cnt_en_a = 1'b0;
    chk("a_hold_zero", bus.trk_idx_a, 0);
    chk("a_skip_b", bus.zero_b, 1);
    for (int i = 0; i < 4; i++) begin
      chk("a_drain_c", bus.trk_idx_c, (i <= 2) ? 2 - i : 0);
      bus.cnt_en_c = 1'b1;
      cyc();
    end
    bus.cnt_en_c = 1'b0;
    chk("a_c_zero", bus.zero_c, 1);
    chk("a_done_early", bus.xing_done, 0);
    bus.proc_bsy = 1'b0;
    #1;
    chk("a_done", bus.xing_done, 1);
    cyc();
    chk("a_done_pulse", bus.xing_done, 0);
    chk_state("a_back_idle", IDLE);

    // All-zero crossing still dispatched.
    push(0, 0, 0);
    wait_start("z", 2);
    finish_xing("z", 4);
    chk("z_zero_a", bus.zero_a, 1);
    chk("z_zero_b", bus.zero_b, 1);
    chk("z_zero_c", bus.zero_c, 1);

    // Fill past capacity while the processor is busy.
    bus.proc_bsy = 1'b1;
    for (int k = 0; k < FIFO_DEPTH; k++) push(k + 1, k + 2, k + 3);
    chk("f_level_full", bus.fifo_level, FIFO_DEPTH);
    chk("f_ready_low", bus.xing_ready, 0);
    bus.xing_valid = 1'b1;
    bus.cnt_a_in   = 6'd9;
    bus.cnt_b_in   = 6'd9;
    bus.cnt_c_in   = 6'd9;
    repeat (2) begin
      cyc();
      chk("f_level_hold", bus.fifo_level, FIFO_DEPTH);
    end
    bus.proc_bsy = 1'b0;
    cyc();
    chk("f_level_pop", bus.fifo_level, FIFO_DEPTH - 1);
    chk("f_ready_back", bus.xing_ready, 1);
    wait_start("f0", 0);
    sb.push_back('{a: 6'd9, b: 6'd9, c: 6'd9});
    bus.proc_bsy = 1'b1;
    cyc();
    bus.xing_valid = 1'b0;
    $display("push  a=9 b=9 c=9 level=%0d", bus.fifo_level);
    chk("f_level_5th", bus.fifo_level, FIFO_DEPTH);
    chk_state("f0_ack", ACK);
    cyc();
    chk_state("f0_busy", BUSY);
    bus.proc_bsy = 1'b0;
    #1;
    chk("f0_done", bus.xing_done, 1);
    cyc();
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      wait_start("f", 3);
      finish_xing("f", 1);
    end
    chk("f_drained", bus.fifo_level, 0);

    // Same-cycle push and pop at level 2, with a load-vs-enable collision.
    bus.proc_bsy = 1'b1;
    push(10, 11, 12);
    push(13, 14, 15);
    chk("s_level2", bus.fifo_level, 2);
    bus.xing_valid = 1'b1;
    bus.cnt_a_in   = 6'd20;
    bus.cnt_b_in   = 6'd21;
    bus.cnt_c_in   = 6'd22;
    sb.push_back('{a: 6'd20, b: 6'd21, c: 6'd22});
    bus.proc_bsy = 1'b0;
    bus.cnt_en_a = 1'b1;
    cyc();
    bus.xing_valid = 1'b0;
    bus.cnt_en_a   = 1'b0;
    chk("s_level_same", bus.fifo_level, 2);
    wait_start("s", 0);
    finish_xing("s", 5);
    wait_start("s2", 3);
    finish_xing("s2", 0);
    wait_start("s3", 3);
    finish_xing("s3", 0);

    // Processor never acknowledges: FSM parks in ACK, no second start.
    push(1, 2, 3);
    wait_start("k", 3);
    repeat (6) begin
      cyc();
      chk_state("k_ack_hold", ACK);
      chk("k_no_restart", bus.start_proc, 0);
    end
    bus.proc_bsy = 1'b1;
    cyc();
    chk_state("k_busy", BUSY);
    bus.proc_bsy = 1'b0;
    #1;
    chk("k_done", bus.xing_done, 1);
    cyc();

    // Reset mid-BUSY with two crossings queued.
    push(7, 8, 9);
    wait_start("r", 3);
    bus.proc_bsy = 1'b1;
    cyc();
    cyc();
    chk_state("r_busy", BUSY);
    push(4, 4, 4);
    push(5, 5, 5);
    chk("r_level2", bus.fifo_level, 2);
    chk("r_zero_a_pre", bus.zero_a, 0);
    res_n = 1'b0;
    #1;
    sb.delete();
    chk("r_async_level", bus.fifo_level, 0);
    chk_state("r_async_state", IDLE);
    cyc();
    chk("r_level", bus.fifo_level, 0);
    chk("r_zero_a", bus.zero_a, 1);
    chk("r_zero_b", bus.zero_b, 1);
    chk("r_zero_c", bus.zero_c, 1);
    chk("r_start", bus.start_proc, 0);
    chk_state("r_state", IDLE);
    res_n        = 1'b1;
    bus.proc_bsy = 1'b0;
    repeat (2) begin
      cyc();
      chk("r_no_dispatch", bus.start_proc, 0);
    end
    chk("r_level_after", bus.fifo_level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tp_crossing_dispatch.md
# tp_crossing_dispatch

Upstream feeder for the crossing-processing state machine. Buffers per-crossing tracklet counts for blocks A, B and C in a small FIFO and dispatches one crossing at a time. For each crossing it loads three down-counters, pulses `start_proc`, and serves `zero_a/b/c` and the current tracklet index while the processor drains each block through `cnt_en_a/b/c`. It sits between the tracklet-block writer and the crossing processor.

## Interface
- `CNT_W`, 6: width of each per-block tracklet count.
- `FIFO_DEPTH`, 4: crossing FIFO entries; power of two, ≥2.
- `clk`  in  1  pipeline clock; all state on rising edge.
- `res_n`  in  1  reset, asynchronous, active-low.
- `xing_valid`  in  1  new crossing counts presented.
- `xing_ready`  out  1  FIFO can accept; equals `!full`.
- `cnt_a_in`, `cnt_b_in`, `cnt_c_in`  in  CNT_W  tracklet counts for the new crossing.
- `proc_bsy`  in  1  processor busy (low only in its IDLE).
- `cnt_en_a`, `cnt_en_b`, `cnt_en_c`  in  1  decrement request for the matching counter.
- `start_proc`  out  1  one-cycle start pulse to the processor.
- `zero_a`, `zero_b`, `zero_c`  out  1  matching counter == 0.
- `trk_idx_a`, `trk_idx_b`, `trk_idx_c`  out  CNT_W  current counter value, used as the tracklet read index.
- `xing_done`  out  1  one-cycle pulse when a dispatched crossing finishes.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  occupied entries.

## Operation
- Push occurs when `xing_valid && xing_ready`; it stores {a,b,c}. When not full, push and pop may happen in the same cycle, and the level is then unchanged. When full, `xing_ready`=0 and the inputs are ignored.
- FSM states:
  - IDLE: if FIFO is non-empty and `proc_bsy`=0, pop and load all three counters, then go to START.
  - START: `start_proc`=1 for this cycle only, then go to ACK.
  - ACK: wait for `proc_bsy`=1, then go to BUSY.
  - BUSY: wait for `proc_bsy`=0; on that cycle pulse `xing_done` and go to IDLE.
- Counters: `cnt_en_x` with counter > 0 decrements it. `cnt_en_x` with counter == 0 is ignored and the counter holds at 0. This is legal: the processor asserts enable on the cycle it observes zero.
- Counters change only by load (IDLE pop) or decrement. Enables outside BUSY still decrement. Load has priority over a same-cycle enable.
- `zero_x` and `trk_idx_x` are combinational from the counter registers.
- A crossing with all counts zero is dispatched normally.
- No wrap-around on counters. FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - state IDLE; FIFO empty; `fifo_level`=0; `xing_ready`=1.
  - counters 0, so `zero_x`=1 and `trk_idx_x`=0.
  - `start_proc`=0; `xing_done`=0.
- Reset asserted mid-crossing aborts immediately and drops all buffered crossings.
- Push at edge t: entry visible (`fifo_level` incremented) after t. Earliest pop is at edge t+1, if IDLE and `proc_bsy`=0.
- Pop/load at edge t: counters and `zero_x` valid in cycle t+1, and `start_proc`=1 in cycle t+1. The processor samples the pulse and enters its first test state at t+2, so the counters are stable one cycle before first use.
- Dispatch overhead is 2 cycles (IDLE→START→ACK) plus 1 cycle from processor IDLE back to the next pop.
- `start_proc` is never asserted while `proc_bsy`=1 was sampled at pop.

## Structure
- Shared package `tp_pkg`: `CNT_W` default, FSM state enum (IDLE, START, ACK, BUSY), and the packed crossing-entry typedef {a,b,c}.
- Sub-module `tp_xing_fifo`: a synchronous FIFO of entries with push/pop/full/empty/level.
- FSM, counters and outputs stay in the top module.

## Test plan
- Reset mid-BUSY with 2 entries queued → next cycle: `fifo_level`=0, `zero_a/b/c`=1, `start_proc`=0, state IDLE.
- Push {3,0,2}, processor model idle:
  - `start_proc` pulses 1 cycle after pop.
  - `trk_idx_a` reads 3,2,1,0 over successive `cnt_en_a`, and the extra enable at 0 holds 0.
  - Block B is skipped; `trk_idx_c` reads 2,1,0.
  - `xing_done` pulses once.
- Push {0,0,0} → dispatched; processor busy for 4 cycles; `xing_done` pulses; no counter changes.
- Push FIFO_DEPTH+1 crossings back-to-back while `proc_bsy`=1:
  - `xing_ready` drops at level 4, and the 5th is not accepted until the first pop.
  - Crossings are dispatched in order.
- Push on the same cycle as a pop at level 2 → level stays 2. Load plus `cnt_en_a` in the same cycle → new value loaded, not decremented.
- `proc_bsy` held high for 5 cycles after `start_proc` by the model → FSM holds in BUSY. `proc_bsy` never rising → FSM holds in ACK with no second `start_proc`.
